// File: rtl/wb_copy_master.sv
// wb_copy_master: Wishbone classic master copying LEN words SRC->DST; optional ack timeout via WBM_TIMEOUT_EN
module wb_copy_master #(
  parameter int LEN_W = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_src_i,
  input  logic [31:0]      cmd_dst_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);
  typedef enum logic [2:0] {IDLE, RD, GAP_W, WR, GAP_R, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, buf_q, buf_d, adr_q, adr_d, dat_q, dat_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [3:0] sel_q, sel_d;
  logic stb_q, stb_d, we_q, we_d, busy_q, done_q, ready_q;
  logic ack, tmo;
  assign ack = wbm_ack_i & stb_q;
`ifdef WBM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_q, wait_d;
  logic err_q;
  assign tmo = stb_q && !wbm_ack_i && (wait_q == CW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    wait_d = (stb_q && !wbm_ack_i) ? wait_q + 1'b1 : '0;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= tmo;
    end
  end
  assign err_o = err_q;
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    if (tmo) begin
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          src_d   = cmd_src_i & ~32'd3;
          dst_d   = cmd_dst_i & ~32'd3;
          rem_d   = cmd_len_i;
          state_d = (cmd_len_i == '0) ? DONE : RD;
        end
        RD: if (ack) begin
          buf_d   = wbm_dat_i;
          state_d = GAP_W;
        end
        GAP_W: state_d = WR;
        WR: if (ack) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_W'(1)) ? DONE : GAP_R;
        end
        GAP_R: state_d = RD;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    stb_d = (state_d == RD) || (state_d == WR);
    we_d  = state_d == WR;
    sel_d = {4{stb_d}};
    adr_d = (state_d == RD) ? src_d : (state_d == WR) ? dst_d : 32'd0;
    dat_d = we_d ? buf_d : 32'd0;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      ready_q <= state_d == IDLE;
    end
  end
  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wbm_cyc_o   = stb_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
endmodule

// File: tb/tb_wb_copy_master.sv
// tb_wb_copy_master: randomized scoreboard bench for wb_copy_master (WBM_TIMEOUT_EN adds the timeout scenario)
module tb_wb_copy_master;
  localparam int TO = 8;
  logic clk = 1'b0, rst_n = 1'b1;
  logic cmd_valid = 1'b0, ack = 1'b0;
  logic [31:0] cmd_src = '0, cmd_dst = '0, dat_i = '0;
  logic [15:0] cmd_len = '0;
  logic ready, busy, done, err, cyc, stb, we;
  logic [3:0] sel;
  logic [31:0] adr, dat;
  always #5 clk = ~clk;
  wb_copy_master #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready),
    .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len), .busy_o(busy),
    .done_o(done), .err_o(err), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} xact_t;
  xact_t exp_q[$];
  bit err_exp_q[$];
  xact_t e;
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int checks = 0, errors = 0;
  int lat_g = 0, wcnt = 0, run = 0;
  bit no_ack = 0, mute = 0, stray = 0;
  logic [31:0] h_adr, h_dat;
  logic h_we;
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  task automatic model(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    logic [31:0] a, b, v;
    for (int i = 0; i < int'(n); i++) begin
      a = (s & ~32'd3) + 32'(4 * i);
      b = (d & ~32'd3) + 32'(4 * i);
      v = ref_rd(a);
      exp_q.push_back('{1'b0, a, 32'd0});
      exp_q.push_back('{1'b1, b, v});
      ref_mem[b] = v;
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      ack = 1'b0; wcnt = 0; run = 0;
    end else begin
      chk("cyc_eq_stb", cyc, stb);
      if (stb) begin
        chk("sel_active", sel, 4'hF);
        if (run > 0) chk("bus_stable", {adr, we, dat}, {h_adr, h_we, h_dat});
        else {h_adr, h_we, h_dat} = {adr, we, dat};
        run++;
        if (no_ack) begin
          chk("no_write_on_timeout", we, 1'b0);
          ack = 1'b0;
        end else if (wcnt == lat_g) begin
          ack = 1'b1;
          if (we) begin mem[adr] = dat; dat_i = $urandom; end
          else dat_i = mem_rd(adr);
          if (!mute) begin
            chk("xact_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("xact_we", we, e.we);
              chk("xact_adr", adr, e.adr);
              if (we) chk("xact_wdat", dat, e.dat);
            end
          end
        end else begin
          ack = 1'b0; wcnt++; dat_i = $urandom;
        end
      end else begin
        chk("sel_idle", sel, 4'h0);
        if (no_ack && run > 0) begin
          chk("timeout_stb_cycles", run, TO);
          chk("timeout_done", done, 1'b1);
        end
        run = 0; wcnt = 0;
        ack = stray && ($urandom_range(0, 3) == 0);
        dat_i = $urandom;
      end
      chk("err_without_done", err & ~done, 1'b0);
      if (done) begin
        chk("done_expected", err_exp_q.size() != 0, 1'b1);
        if (err_exp_q.size() != 0) chk("err_flag", err, err_exp_q.pop_front());
        chk("bus_drained_at_done", exp_q.size(), 0);
        chk("busy_at_done", busy, 1'b1);
      end
    end
  end
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input int lat, input bit to);
    int w, c, exp_c;
    lat_g = lat; no_ack = to;
    w = 0;
    while (!ready && w < 200) begin @(negedge clk); w++; end
    chk("ready_wait", ready, 1'b1);
    if (!to) model(s, d, n);
    err_exp_q.push_back(to);
    cmd_src = s; cmd_dst = d; cmd_len = n; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 1 && !done) begin
        cmd_valid = 1'b1; cmd_src = $urandom; cmd_dst = $urandom; cmd_len = 16'($urandom);
      end else cmd_valid = 1'b0;
    end while (!done && c < 5000);
    cmd_valid = 1'b0;
    exp_c = to ? TO + 1 : (n == 0) ? 1 : int'(n) * (2 * lat + 4);
    chk("done_latency", c, exp_c);
    @(negedge clk);
    chk("idle_after_done", {busy, ready}, 2'b01);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    int w;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", {cyc, stb, we, sel, busy, done, err, ready, adr, dat}, {10'd1, 64'd0});
    repeat (3) @(negedge clk);
    chk("reset_held", {cyc, stb, we, sel, busy, done, err, ready}, 11'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_release", {cyc, busy, ready}, 3'b001);
    issue(32'h3800_0000, 32'h3800_0100, 16'd3, 1, 1'b0);
    issue(32'h3800_0040, 32'h3800_0140, 16'd0, 0, 1'b0);
    issue(32'h3800_0010, 32'h3800_0200, 16'd2, 5, 1'b0);
    issue(32'h3800_0023, 32'h3800_0302, 16'd2, 0, 1'b0);
    lat_g = 6; no_ack = 0; mute = 1;
    cmd_src = 32'h3800_0080; cmd_dst = 32'h3800_0180; cmd_len = 16'd1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!(stb && we) && w < 100);
    chk("reached_write", stb && we, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_write", {cyc, stb, we, sel, busy, done, err, ready}, 11'd1);
    repeat (3) @(negedge clk);
    chk("no_done_after_abort", done, 1'b0);
    rst_n = 1'b1; mute = 0;
    exp_q.delete();
    ref_mem = mem;
    @(negedge clk);
    chk("ready_after_abort", ready, 1'b1);
    issue(32'h3800_0080, 32'h3800_0180, 16'd1, 0, 1'b0);
    issue(32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd3, 0, 1'b0);
    stray = 1;
    for (int k = 0; k < 20; k++)
      issue(32'h3800_0000 + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3)),
            32'h3800_0000 + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3)),
            16'($urandom_range(0, 6)), $urandom_range(0, 4), 1'b0);
`ifdef WBM_TIMEOUT_EN
    issue(32'h3800_0000, 32'h3800_0400, 16'd5, 0, 1'b1);
    issue(32'h3800_0000, 32'h3800_0400, 16'd2, 2, 1'b0);
`endif
    repeat (3) @(negedge clk);
    chk("final_idle", {cyc, busy, ready}, 3'b001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
